// File: rtl/gate_tester_if.sv
// gate_tester_if: stimulus/response bundle between gate_tester and its environment.
//   start      environment -> tester   begin a run
//   dut_y      DUT -> tester           DUT response
//   dut_in     tester -> DUT           registered stimulus vector
//   busy, done, pass, err_count        tester status
//   first_fail                         first mismatching vector (GATE_TESTER_FAIL_LOG_EN only)
// The slave modport is the tester side; master is the environment side.
interface gate_tester_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic [N_IN-1:0] dut_in;
    logic            dut_y;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
`ifdef GATE_TESTER_FAIL_LOG_EN
    logic [N_IN-1:0] first_fail;
    modport master (output start, dut_y, input dut_in, busy, done, pass, err_count, first_fail);
    modport slave  (input start, dut_y, output dut_in, busy, done, pass, err_count, first_fail);
`else
    modport master (output start, dut_y, input dut_in, busy, done, pass, err_count);
    modport slave  (input start, dut_y, output dut_in, busy, done, pass, err_count);
`endif
endinterface

// File: rtl/gate_tester.sv
// gate_tester: exhaustive stimulus/response checker for an N_IN-input, 1-output gate.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  gate_tester_if.slave: start/dut_y in; dut_in/busy/done/pass/err_count
//        (and first_fail when GATE_TESTER_FAIL_LOG_EN is defined) out
// Each vector is held SETTLE cycles in WAIT, then sampled and compared in one CHECK cycle.
module gate_tester #(
    parameter int                 N_IN   = 2,
    parameter logic [2**N_IN-1:0] TRUTH  = 4'b1000,
    parameter int                 SETTLE = 2
) (
    input logic         clk,
    input logic         rst,
    gate_tester_if.slave bus
);
    localparam int CW = $clog2(SETTLE + 1);
    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;
    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_IN:0]   err_q, err_d;
    logic            miss;
`ifdef GATE_TESTER_FAIL_LOG_EN
    logic [N_IN-1:0] ff_q, ff_d;
`endif
    // Case inequality so an X/Z response counts as a mismatch.
    assign miss = bus.dut_y !== TRUTH[vec_q];
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
`ifdef GATE_TESTER_FAIL_LOG_EN
        ff_d    = ff_q;
`endif
        case (state_q)
            IDLE, DONE: if (bus.start) begin
                state_d = WAIT;
                vec_d   = '0;
                cnt_d   = '0;
                err_d   = '0;
`ifdef GATE_TESTER_FAIL_LOG_EN
                ff_d    = '0;
`endif
            end
            WAIT: begin
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(SETTLE - 1)) ? CHECK : WAIT;
            end
            CHECK: begin
                err_d = miss ? err_q + (N_IN+1)'(1) : err_q;
`ifdef GATE_TESTER_FAIL_LOG_EN
                // Only the first mismatch of a run is logged.
                ff_d  = (miss && err_q == '0) ? vec_q : ff_q;
`endif
                if (&vec_q) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                    vec_d   = vec_q + N_IN'(1);
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
`ifdef GATE_TESTER_FAIL_LOG_EN
            ff_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef GATE_TESTER_FAIL_LOG_EN
            ff_q    <= ff_d;
`endif
        end
    end
    assign bus.dut_in    = vec_q;
    assign bus.busy      = (state_q == WAIT) || (state_q == CHECK);
    assign bus.done      = state_q == DONE;
    assign bus.pass      = (state_q == DONE) && (err_q == '0);
    assign bus.err_count = err_q;
`ifdef GATE_TESTER_FAIL_LOG_EN
    assign bus.first_fail = ff_q;
`endif
endmodule

// File: tb/tb_gate_tester.sv
// tb_gate_tester: directed checks of gate_tester against hand-computed results.
module tb_gate_tester;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   mode = 0;
    logic xv = 1'bx;
    int   n;
    int   trace [0:127];
    logic e0_busy, e0_done;
    int   e0_din, e0_err;
    int   exp_x;
    gate_tester_if #(.N_IN(2)) if0 ();
    gate_tester_if #(.N_IN(2)) if1 ();
    gate_tester #(.N_IN(2), .TRUTH(4'b1000), .SETTLE(2)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    gate_tester #(.N_IN(2), .TRUTH(4'b1111), .SETTLE(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    always #5 clk = ~clk;
    // mode 0: AND, 1: OR, 2: AND with xv driven on vector 2
    always_comb
        if0.dut_y = (mode == 1) ? |if0.dut_in :
                    (mode == 2 && if0.dut_in == 2'd2) ? xv : &if0.dut_in;
    assign if1.dut_y = 1'b0;
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    // Pulse start on u0, record state right after E0 and dut_in after every edge,
    // optionally re-pulse start so it is sampled at edge restart_at.
    task automatic run0(input int restart_at, output int edges);
        @(negedge clk);
        if0.start = 1'b1;
        @(posedge clk);
        #1;
        e0_busy = if0.busy;
        e0_done = if0.done;
        e0_din  = int'(if0.dut_in);
        e0_err  = int'(if0.err_count);
        edges = 0;
        if0.start = (restart_at == 1);
        while (!if0.done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            trace[edges] = int'(if0.dut_in);
            if0.start = (edges + 1 == restart_at);
        end
        if0.start = 1'b0;
    endtask
    initial begin
        if0.start = 1'b0;
        if1.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dut_in", int'(if0.dut_in), 0);
        chk("rst_busy", int'(if0.busy), 0);
        chk("rst_done", int'(if0.done), 0);
        chk("rst_pass", int'(if0.pass), 0);
        chk("rst_err", int'(if0.err_count), 0);
        chk("rst1_done", int'(if1.done), 0);
`ifdef GATE_TESTER_FAIL_LOG_EN
        chk("rst_ff", int'(if0.first_fail), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        // AND gate against AND table
        mode = 0;
        run0(-1, n);
        chk("and_e0_busy", int'(e0_busy), 1);
        chk("and_e0_din", e0_din, 0);
        chk("and_edges", n, 12);
        chk("and_din_e2", trace[2], 0);
        chk("and_din_e3", trace[3], 1);
        chk("and_din_e6", trace[6], 2);
        chk("and_din_e9", trace[9], 3);
        chk("and_din_e11", trace[11], 3);
        chk("and_err", int'(if0.err_count), 0);
        chk("and_pass", int'(if0.pass), 1);
        chk("and_busy", int'(if0.busy), 0);
        // OR gate: vectors 1 and 2 mismatch
        mode = 1;
        run0(-1, n);
        chk("or_edges", n, 12);
        chk("or_err", int'(if0.err_count), 2);
        chk("or_pass", int'(if0.pass), 0);
`ifdef GATE_TESTER_FAIL_LOG_EN
        chk("or_ff", int'(if0.first_fail), 1);
`endif
        // start in DONE clears results on the same edge
        mode = 0;
        run0(-1, n);
        chk("re_e0_err", e0_err, 0);
        chk("re_e0_done", int'(e0_done), 0);
        chk("re_e0_busy", int'(e0_busy), 1);
        chk("re_edges", n, 12);
        chk("re_pass", int'(if0.pass), 1);
`ifdef GATE_TESTER_FAIL_LOG_EN
        chk("re_ff", int'(if0.first_fail), 0);
`endif
        // start re-pulsed at edge 5 mid-run is ignored
        run0(5, n);
        chk("busy_start_edges", n, 12);
        chk("busy_start_err", int'(if0.err_count), 0);
        // asynchronous reset mid-run with a partial error count
        mode = 1;
        @(negedge clk);
        if0.start = 1'b1;
        @(posedge clk);
        #1;
        if0.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("pre_rst_err", int'(if0.err_count), 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_dut_in", int'(if0.dut_in), 0);
        chk("arst_busy", int'(if0.busy), 0);
        chk("arst_done", int'(if0.done), 0);
        chk("arst_err", int'(if0.err_count), 0);
        chk("arst_pass", int'(if0.pass), 0);
        @(negedge clk);
        rst = 1'b0;
        mode = 0;
        run0(-1, n);
        chk("post_rst_edges", n, 12);
        chk("post_rst_pass", int'(if0.pass), 1);
        // unknown response on vector 2; AND table expects 0 there
        mode = 2;
        exp_x = (xv !== 1'b0) ? 1 : 0;
        run0(-1, n);
        chk("x_err", int'(if0.err_count), exp_x);
        chk("x_pass", int'(if0.pass), 1 - exp_x);
`ifdef GATE_TESTER_FAIL_LOG_EN
        chk("x_ff", int'(if0.first_fail), 2 * exp_x);
`endif
        // SETTLE=1, output stuck 0 against all-ones table: saturates at 4
        @(negedge clk);
        if1.start = 1'b1;
        @(posedge clk);
        #1;
        if1.start = 1'b0;
        n = 0;
        while (!if1.done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("s1_edges", n, 8);
        chk("s1_err", int'(if1.err_count), 4);
        chk("s1_pass", int'(if1.pass), 0);
`ifdef GATE_TESTER_FAIL_LOG_EN
        chk("s1_ff", int'(if1.first_fail), 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gate_tester.md
# gate_tester

Synthesizable self-checking stimulus/response engine for small combinational gates. It drives every input combination of an N-input, 1-output device under test (DUT), waits a fixed settle time, samples the DUT output and compares it against a parameterised truth table. It reports an error count and pass/done flags. It is the in-hardware counterpart of our simulation gate benches: it produces stimulus and consumes the response, so gate blocks can be checked on an FPGA with no simulator.

## Interface
Parameters:
- `N_IN`, 2: number of DUT inputs; legal range 1..6.
- `TRUTH`, 4'b1000: expected output, width 2**N_IN; bit v is the expected `dut_y` for input vector v (default is AND).
- `SETTLE`, 2: cycles each vector is held before sampling; legal value ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE or DONE.
- `dut_in`  out  N_IN  stimulus vector to the DUT; registered.
- `dut_y`  in  1  DUT response.
- `busy`  out  1  high in WAIT and CHECK.
- `done`  out  1  high in DONE; level, held until the next start or reset.
- `pass`  out  1  `done && err_count==0`.
- `err_count`  out  N_IN+1  mismatches in the current/last run.
- `first_fail`  out  N_IN  first mismatching vector; present only with the macro enabled, see Configuration.

## Operation
- States:
  - IDLE: after reset.
  - WAIT: hold vector.
  - CHECK: sample and compare.
  - DONE: results valid.
- IDLE/DONE with `start`=1 → WAIT:
  - `vec`=0, `dut_in`=0.
  - Settle counter cleared.
  - `err_count`=0 and `first_fail`=0.
  - `done` deasserts.
- WAIT: the counter increments each cycle. After SETTLE cycles in WAIT → CHECK.
- CHECK (1 cycle): `dut_y` is sampled at the closing edge.
  - If `dut_y != TRUTH[vec]`, `err_count`++.
  - X/Z on `dut_y` counts as a mismatch; use a case-inequality compare.
  - If `vec == 2**N_IN-1` → DONE. Otherwise `vec`++, `dut_in` updates, counter clears, → WAIT.
- `start` while busy is ignored. A run cannot be aborted except by `rst`.
- `err_count` width N_IN+1 holds the maximum 2**N_IN with no overflow and no wrap.
- `dut_in` wraps never: the run ends at all-ones.

## Timing
- Reset values (immediate, asynchronous):
  - state=IDLE.
  - `dut_in`=0, `busy`=0, `done`=0, `pass`=0.
  - `err_count`=0, `first_fail`=0.
- `start` is sampled at edge E0. `busy`=1 and `dut_in`=0 are visible after E0.
- Each vector occupies exactly SETTLE+1 cycles: SETTLE in WAIT plus 1 in CHECK.
- `done` rises exactly 2**N_IN*(SETTLE+1) edges after E0. `busy` falls on the same edge.
- DUT combinational delay must be < SETTLE clock periods.
- In DONE, `start`=1 starts a new run at that edge. Results clear on that same edge.
- `rst` mid-run returns to IDLE at once. A partial `err_count` is discarded (0).
- `pass` is combinational from registered `done`/`err_count` only, so it is glitch-free.

## Configuration
- `GATE_TESTER_FAIL_LOG_EN`:
  - Defined: the `first_fail` port and register exist. On the first CHECK mismatch of a run (`err_count` 0→1), `first_fail` captures `vec`. Later mismatches do not overwrite it. It resets/clears to 0 at reset and at run start.
  - Undefined: the port and register are absent. All other behaviour is identical.

## Test plan
- AND DUT, N_IN=2, TRUTH=4'b1000, SETTLE=2, pulse `start`:
  - `dut_in` steps 0,1,2,3 every 3 cycles.
  - `done`=1 at edge 12, `err_count`=0, `pass`=1.
- OR DUT with TRUTH=4'b1000: `err_count`=2, `pass`=0, `first_fail`=1 (FAIL_LOG_EN defined).
- SETTLE=1, DUT tied `dut_y`=0, TRUTH=4'b1111:
  - `done` at edge 8, `err_count`=4 (max, no wrap).
  - `first_fail`=0.
- `start` pulsed again at edge 5 during a run: no effect, `done` still at edge 12. Then `start` in DONE: `err_count` clears, new run completes at +12.
- Assert `rst` asynchronously at cycle 7 mid-run:
  - All outputs are 0 immediately, state IDLE.
  - A subsequent start runs a full, correct pass.
- `dut_y` driven X on vector 2 (AND DUT otherwise): `err_count`=1, `pass`=0, `first_fail`=2.
